// File: rtl/bus_interface_unit.sv
// bus_interface_unit: turns one byte/word memory request into 8086-style
// T1..T4 bus cycles on a 16-bit bus with A0/BHE_n lanes, wait states and timeout.
module bus_interface_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_word,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_rdata,
  output logic [19:0] bus_addr,
  output logic        bus_ale,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_bhe_n,
  output logic [15:0] bus_dout,
  output logic        bus_dout_en,
  input  logic [15:0] bus_din,
  input  logic        bus_ready,
  output logic        busy
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  state_t          state_q, next_state;

  // Latched request context; addr_q is the address of the current bus cycle
  logic            we_q, word_q, split_q, second_q, abort_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [7:0]      lo_byte_q;

  // Context of the bus cycle about to start
  logic            nx_we, nx_word, nx_split, nx_second, nx_bhe_n;
  logic [AW-1:0]   nx_addr;
  logic [DW-1:0]   nx_wdata, nx_dout;

  logic            timeout, ready_hit, last_cycle, strobe;
  logic [DW-1:0]   rd_d;

  logic            req_ready_d, busy_d, resp_valid_d, resp_err_d;
  logic            bus_ale_d, bus_rd_n_d, bus_wr_n_d, bus_bhe_n_d, bus_dout_en_d;
  logic [DW-1:0]   resp_rdata_d, bus_dout_d;
  logic [AW-1:0]   bus_addr_d;

  assign timeout    = (state_q == T3) && !bus_ready && (wait_cnt_q == CW'(MAX_WAIT));
  assign ready_hit  = (state_q == T3) && bus_ready;
  assign last_cycle = !split_q || second_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    if (req_valid && req_ready) next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      if (bus_ready || timeout) next_state = T4;
      T4:      next_state = (split_q && !second_q && !abort_q) ? T1 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address, lane and write data for the next T1 (new request or second half)
  always_comb begin
    nx_we     = we_q;
    nx_word   = word_q;
    nx_split  = split_q;
    nx_second = 1'b1;
    nx_wdata  = wdata_q;
    nx_addr   = addr_q + AW'(1);
    if (state_q == IDLE) begin
      nx_we     = req_we;
      nx_word   = req_word;
      nx_split  = req_word & req_addr[0];
      nx_second = 1'b0;
      nx_wdata  = req_wdata;
      nx_addr   = req_addr;
    end
    nx_bhe_n = ~(nx_addr[0] | (nx_word & ~nx_split));
    if (nx_word && !nx_split) nx_dout = nx_wdata;
    else if (nx_second)       nx_dout = {2{nx_wdata[15:8]}};
    else                      nx_dout = {2{nx_wdata[7:0]}};
  end

  // Read data assembly for the completing cycle
  always_comb begin
    if (!word_q)       rd_d = {8'h00, (addr_q[0] ? bus_din[15:8] : bus_din[7:0])};
    else if (!split_q) rd_d = bus_din;
    else               rd_d = {bus_din[7:0], lo_byte_q};
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    strobe        = (next_state == T2) || (next_state == T3);
    req_ready_d   = (next_state == IDLE);
    busy_d        = (next_state != IDLE);
    resp_valid_d  = (next_state == T4) && (timeout || last_cycle);
    resp_err_d    = (next_state == T4) && timeout;
    resp_rdata_d  = resp_rdata;
    bus_addr_d    = bus_addr;
    bus_bhe_n_d   = bus_bhe_n;
    bus_dout_d    = bus_dout;
    bus_ale_d     = (next_state == T1);
    bus_rd_n_d    = ~(strobe & ~we_q);
    bus_wr_n_d    = ~(strobe & we_q);
    bus_dout_en_d = strobe & we_q;
    if (ready_hit && !we_q && last_cycle) resp_rdata_d = rd_d;
    if (next_state == T1) begin
      bus_addr_d  = nx_addr;
      bus_bhe_n_d = nx_bhe_n;
      bus_dout_d  = nx_dout;
    end else if (next_state == IDLE) begin
      bus_bhe_n_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      bus_addr    <= '0;
      bus_ale     <= 1'b0;
      bus_rd_n    <= 1'b1;
      bus_wr_n    <= 1'b1;
      bus_bhe_n   <= 1'b1;
      bus_dout    <= '0;
      bus_dout_en <= 1'b0;
    end else begin
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
      bus_addr    <= bus_addr_d;
      bus_ale     <= bus_ale_d;
      bus_rd_n    <= bus_rd_n_d;
      bus_wr_n    <= bus_wr_n_d;
      bus_bhe_n   <= bus_bhe_n_d;
      bus_dout    <= bus_dout_d;
      bus_dout_en <= bus_dout_en_d;
    end
  end

  // Request context, wait counter and split-read low byte
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      split_q    <= 1'b0;
      second_q   <= 1'b0;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      lo_byte_q  <= '0;
    end else begin
      if (next_state == T1) begin
        we_q       <= nx_we;
        word_q     <= nx_word;
        split_q    <= nx_split;
        second_q   <= nx_second;
        wdata_q    <= nx_wdata;
        addr_q     <= nx_addr;
        wait_cnt_q <= '0;
        abort_q    <= 1'b0;
      end else if (state_q == T3 && !bus_ready) begin
        if (timeout) abort_q    <= 1'b1;
        else         wait_cnt_q <= wait_cnt_q + CW'(1);
      end
      if (ready_hit && split_q && !second_q) lo_byte_q <= bus_din[15:8];
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed self-checking bench for bus_interface_unit.
module tb_bus_interface_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_word;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic [19:0] bus_addr;
  logic        bus_ale, bus_rd_n, bus_wr_n, bus_bhe_n, bus_dout_en, bus_ready, busy;
  logic [15:0] bus_dout, bus_din;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  bus_interface_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .bus_addr(bus_addr), .bus_ale(bus_ale), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_bhe_n(bus_bhe_n), .bus_dout(bus_dout), .bus_dout_en(bus_dout_en),
    .bus_din(bus_din), .bus_ready(bus_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a request for one edge; returns in cycle 1 (T1)
  task automatic do_req(input logic we, input logic word, input logic [19:0] addr,
                        input logic [15:0] wd);
    check("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; bus_din = '0; bus_ready = 1'b1;
    step(2);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_ale", bus_ale, 0);
    check("rst_rd_n", bus_rd_n, 1);
    check("rst_wr_n", bus_wr_n, 1);
    check("rst_bhe_n", bus_bhe_n, 1);
    check("rst_dout", bus_dout, 0);
    check("rst_dout_en", bus_dout_en, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(1);
    check("post_rst_req_ready", req_ready, 1);

    // Even word read
    bus_din = 16'hBEEF; bus_ready = 1'b1;
    do_req(1'b0, 1'b1, 20'h12340, 16'h0000);
    check("ew_ale_t1", bus_ale, 1);
    check("ew_addr_t1", bus_addr, 32'h12340);
    check("ew_bhe_t1", bus_bhe_n, 0);
    check("ew_busy_t1", busy, 1);
    check("ew_ready_t1", req_ready, 0);
    check("ew_rd_t1", bus_rd_n, 1);
    step(1);
    check("ew_ale_t2", bus_ale, 0);
    check("ew_rd_t2", bus_rd_n, 0);
    check("ew_wr_t2", bus_wr_n, 1);
    step(1);
    check("ew_rd_t3", bus_rd_n, 0);
    check("ew_resp_t3", resp_valid, 0);
    step(1);
    check("ew_resp_t4", resp_valid, 1);
    check("ew_rdata", resp_rdata, 32'hBEEF);
    check("ew_err", resp_err, 0);
    check("ew_rd_t4", bus_rd_n, 1);
    step(1);
    check("ew_resp_clear", resp_valid, 0);
    check("ew_ready_again", req_ready, 1);
    check("ew_busy_idle", busy, 0);

    // Odd word read: two byte cycles
    bus_din = 16'hAA55;
    do_req(1'b0, 1'b1, 20'h12341, 16'h0000);
    check("ow_addr1", bus_addr, 32'h12341);
    check("ow_bhe1", bus_bhe_n, 0);
    step(3);
    check("ow_resp_mid", resp_valid, 0);
    check("ow_rd_mid_t4", bus_rd_n, 1);
    step(1);
    check("ow_ale2", bus_ale, 1);
    check("ow_addr2", bus_addr, 32'h12342);
    check("ow_bhe2", bus_bhe_n, 1);
    bus_din = 16'h3377;
    step(3);
    check("ow_resp", resp_valid, 1);
    check("ow_rdata", resp_rdata, 32'h77AA);
    check("ow_err", resp_err, 0);
    step(1);

    // Odd byte write
    do_req(1'b1, 1'b0, 20'h00003, 16'h00C3);
    check("ob_addr", bus_addr, 32'h00003);
    check("ob_bhe", bus_bhe_n, 0);
    step(1);
    check("ob_wr_t2", bus_wr_n, 0);
    check("ob_rd_t2", bus_rd_n, 1);
    check("ob_dout_en_t2", bus_dout_en, 1);
    check("ob_dout", bus_dout, 32'hC3C3);
    step(1);
    check("ob_wr_t3", bus_wr_n, 0);
    step(1);
    check("ob_resp", resp_valid, 1);
    check("ob_err", resp_err, 0);
    check("ob_wr_t4", bus_wr_n, 1);
    check("ob_dout_en_t4", bus_dout_en, 0);
    step(1);

    // Request held while busy is taken once the unit is idle again
    bus_din = 16'h0F0F;
    do_req(1'b1, 1'b1, 20'h00200, 16'hA5A5);
    check("hr_dout", bus_dout, 32'hA5A5);
    check("hr_bhe", bus_bhe_n, 0);
    req_valid = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 20'h00300;
    check("hr_ready_busy", req_ready, 0);
    step(3);
    check("hr_addr_hold", bus_addr, 32'h00200);
    check("hr_resp1", resp_valid, 1);
    step(1);
    check("hr_ready_idle", req_ready, 1);
    step(1);
    req_valid = 1'b0;
    check("hr_ale2", bus_ale, 1);
    check("hr_addr2", bus_addr, 32'h00300);
    step(3);
    check("hr_resp2", resp_valid, 1);
    check("hr_rdata2", resp_rdata, 32'h0F0F);
    step(1);

    // Three wait states on an even byte read
    bus_din = 16'h1122; bus_ready = 1'b0;
    do_req(1'b0, 1'b0, 20'h00010, 16'h0000);
    check("ws_bhe", bus_bhe_n, 1);
    step(5);
    check("ws_rd_wait", bus_rd_n, 0);
    check("ws_resp_wait", resp_valid, 0);
    bus_ready = 1'b1;
    step(1);
    check("ws_resp", resp_valid, 1);
    check("ws_rdata", resp_rdata, 32'h0022);
    check("ws_err", resp_err, 0);
    step(1);

    // Timeout on the first half of an odd word read
    bus_ready = 1'b0;
    do_req(1'b0, 1'b1, 20'h00021, 16'h0000);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      step(1);
      lat++;
    end
    check("to_latency", lat, 19);
    check("to_err", resp_err, 1);
    check("to_rdata_held", resp_rdata, 32'h0022);
    check("to_no_second", bus_addr, 32'h00021);
    step(1);
    check("to_ready", req_ready, 1);
    check("to_busy", busy, 0);
    bus_ready = 1'b1;

    // Odd word write wrapping at the top of memory
    do_req(1'b1, 1'b1, 20'hFFFFF, 16'h1234);
    check("wr_addr1", bus_addr, 32'hFFFFF);
    check("wr_bhe1", bus_bhe_n, 0);
    check("wr_dout_hi", bus_dout[15:8], 32'h34);
    step(1);
    check("wr_wr_t2", bus_wr_n, 0);
    step(3);
    check("wr_ale2", bus_ale, 1);
    check("wr_addr2", bus_addr, 32'h00000);
    check("wr_bhe2", bus_bhe_n, 1);
    step(1);
    check("wr_dout_lo", bus_dout[7:0], 32'h12);
    check("wr_dout_en2", bus_dout_en, 1);
    step(2);
    check("wr_resp", resp_valid, 1);
    check("wr_err", resp_err, 0);
    step(1);

    // Reset during T3 of a read
    bus_ready = 1'b0;
    do_req(1'b0, 1'b1, 20'h00100, 16'h0000);
    step(2);
    check("rm_rd_t3", bus_rd_n, 0);
    rst = 1'b1;
    step(1);
    check("rm_rd", bus_rd_n, 1);
    check("rm_wr", bus_wr_n, 1);
    check("rm_busy", busy, 0);
    check("rm_resp", resp_valid, 0);
    check("rm_ale", bus_ale, 0);
    check("rm_rdata", resp_rdata, 0);
    rst = 1'b0; bus_ready = 1'b1;
    step(1);
    check("rm_ready", req_ready, 1);
    check("rm_resp_after", resp_valid, 0);
    bus_din = 16'h5A00;
    do_req(1'b0, 1'b0, 20'h00005, 16'h0000);
    check("nr_addr", bus_addr, 32'h00005);
    check("nr_bhe", bus_bhe_n, 0);
    step(3);
    check("nr_resp", resp_valid, 1);
    check("nr_rdata", resp_rdata, 32'h005A);
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
